// File: rtl/psg_multi.sv
// psg_multi: CH-channel square-wave sound generator with one shared 17-bit
// noise LFSR and one shared 32-step envelope. Each channel produces a
// registered 5-bit log level.
// Ports: CLK/RESET (sync, active-high), CE generator enable, WR/ADDR/DIN
// register write port, DOUT registered read data (1-cycle latency),
// LEVEL packed per-channel levels (ch i at [5i+4:5i]), MIX linear sum.
// Optional macro PSG_MIX_EN builds the log-to-linear table and the MIX adder;
// without it MIX is tied to 0.
module psg_multi #(
  parameter int CH  = 3,
  parameter int TW  = 12,
  parameter int DIV = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CE,
  input  logic            WR,
  input  logic [4:0]      ADDR,
  input  logic [7:0]      DIN,
  output logic [7:0]      DOUT,
  output logic [5*CH-1:0] LEVEL,
  output logic [10:0]     MIX
);
  localparam logic [4:0] A_NPER  = 5'(2*CH);
  localparam logic [4:0] A_TDIS  = 5'(2*CH+1);
  localparam logic [4:0] A_NDIS  = 5'(2*CH+2);
  localparam logic [4:0] A_VOL   = 5'(2*CH+3);
  localparam logic [4:0] A_ELO   = 5'(3*CH+3);
  localparam logic [4:0] A_EHI   = 5'(3*CH+4);
  localparam logic [4:0] A_SHAPE = 5'(3*CH+5);
  localparam logic [3:0] PRE_MAX = 4'(DIV-1);

  // Programmer-visible registers
  logic [TW-1:0]   tper_q [CH];
  logic [TW-1:0]   tper_d [CH];
  logic [4:0]      vol_q  [CH];
  logic [4:0]      vol_d  [CH];
  logic [4:0]      nper_q, nper_d;
  logic [CH-1:0]   tdis_q, tdis_d, ndis_q, ndis_d;
  logic [15:0]     eper_q, eper_d;
  logic [3:0]      shape_q, shape_d;   // {C, At, Al, H}

  // Generator state
  logic [3:0]      pre_q, pre_d;
  logic            ntog_q, ntog_d;
  logic [TW-1:0]   tcnt_q [CH];
  logic [TW-1:0]   tcnt_d [CH];
  logic [CH-1:0]   tone_q, tone_d;
  logic [4:0]      ncnt_q, ncnt_d;
  logic [16:0]     lfsr_q, lfsr_d;
  logic [15:0]     ecnt_q, ecnt_d;
  logic [4:0]      step_q, step_d;
  logic            inv_q, inv_d, hold_q, hold_d;
  logic [7:0]      dout_q, dout_d;
  logic [5*CH-1:0] level_q, level_d;

  logic            tick, ntick, etick, shape_wr, gate;
  logic [TW-1:0]   tlast;
  logic [4:0]      nlast, env_lvl;
  logic [15:0]     elast;

  always_comb begin
    tper_d  = tper_q;   vol_d  = vol_q;   nper_d = nper_q;
    tdis_d  = tdis_q;   ndis_d = ndis_q;  eper_d = eper_q;
    shape_d = shape_q;  pre_d  = pre_q;   ntog_d = ntog_q;
    tcnt_d  = tcnt_q;   tone_d = tone_q;  ncnt_d = ncnt_q;
    lfsr_d  = lfsr_q;   ecnt_d = ecnt_q;  step_d = step_q;
    inv_d   = inv_q;    hold_d = hold_q;
    tlast   = '0;       gate   = 1'b0;
    level_d = '0;       dout_d = 8'hFF;

    // Register writes; unmapped addresses simply match nothing.
    if (WR) begin
      for (int i = 0; i < CH; i++) begin
        if (ADDR == 5'(2*i))       tper_d[i][7:0]    = DIN;
        if (ADDR == 5'(2*i+1))     tper_d[i][TW-1:8] = DIN[TW-9:0];
        if (ADDR == A_VOL + 5'(i)) vol_d[i]          = DIN[4:0];
      end
      if (ADDR == A_NPER)  nper_d       = DIN[4:0];
      if (ADDR == A_TDIS)  tdis_d       = DIN[CH-1:0];
      if (ADDR == A_NDIS)  ndis_d       = DIN[CH-1:0];
      if (ADDR == A_ELO)   eper_d[7:0]  = DIN;
      if (ADDR == A_EHI)   eper_d[15:8] = DIN;
      if (ADDR == A_SHAPE) shape_d      = DIN[3:0];
    end
    shape_wr = WR && (ADDR == A_SHAPE);

    // Prescaler: one tick per DIV CE pulses; noise runs on every 2nd tick.
    tick  = CE && (pre_q == PRE_MAX);
    ntick = tick && ntog_q;
    if (CE)   pre_d  = tick ? 4'd0 : pre_q + 4'd1;
    if (tick) ntog_d = ~ntog_q;

    // Tone counters: ">=" makes a period shrunk below the count wrap at once.
    for (int i = 0; i < CH; i++) begin
      tlast = (tper_q[i] == '0) ? '0 : tper_q[i] - TW'(1);
      if (tick) begin
        if (tcnt_q[i] >= tlast) begin
          tcnt_d[i] = '0;
          tone_d[i] = ~tone_q[i];
        end else begin
          tcnt_d[i] = tcnt_q[i] + TW'(1);
        end
      end
    end

    // Noise counter and LFSR
    nlast = (nper_q == 5'd0) ? 5'd0 : nper_q - 5'd1;
    if (ntick) begin
      if (ncnt_q >= nlast) begin
        ncnt_d = 5'd0;
        lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        ncnt_d = ncnt_q + 5'd1;
      end
    end

    // Envelope: a shape write restarts it regardless of CE.
    elast = (eper_q == 16'd0) ? 16'd0 : eper_q - 16'd1;
    etick = tick && (ecnt_q >= elast);
    if (shape_wr) begin
      step_d = 5'd0;
      inv_d  = 1'b0;
      hold_d = 1'b0;
      ecnt_d = 16'd0;
    end else if (tick) begin
      ecnt_d = etick ? 16'd0 : ecnt_q + 16'd1;
      if (etick && !hold_q) begin
        if (step_q != 5'd31) begin
          step_d = step_q + 5'd1;
        end else if (!shape_q[3]) begin
          hold_d = 1'b1;
        end else if (shape_q[0]) begin
          hold_d = 1'b1;
          inv_d  = inv_q ^ shape_q[1];
        end else begin
          step_d = 5'd0;
          if (shape_q[1]) inv_d = ~inv_q;
        end
      end
    end
    // A non-continuing shape parks at silence once it has held.
    if (hold_q && !shape_q[3])     env_lvl = 5'd0;
    else if (shape_q[2] ^ inv_q)   env_lvl = step_q;
    else                           env_lvl = 5'd31 - step_q;

    // Per-channel mixer
    for (int i = 0; i < CH; i++) begin
      gate = (tone_q[i] | tdis_q[i]) & (lfsr_q[0] | ndis_q[i]);
      if (!gate)            level_d[5*i +: 5] = 5'd0;
      else if (vol_q[i][4]) level_d[5*i +: 5] = env_lvl;
      else                  level_d[5*i +: 5] = {vol_q[i][3:0], vol_q[i][3]};
    end

    // Read mux: unstored bits read 0, unmapped addresses read 0xFF.
    for (int i = 0; i < CH; i++) begin
      if (ADDR == 5'(2*i))       dout_d = tper_q[i][7:0];
      if (ADDR == 5'(2*i+1))     dout_d = 8'(tper_q[i][TW-1:8]);
      if (ADDR == A_VOL + 5'(i)) dout_d = 8'(vol_q[i]);
    end
    if (ADDR == A_NPER)  dout_d = 8'(nper_q);
    if (ADDR == A_TDIS)  dout_d = 8'(tdis_q);
    if (ADDR == A_NDIS)  dout_d = 8'(ndis_q);
    if (ADDR == A_ELO)   dout_d = eper_q[7:0];
    if (ADDR == A_EHI)   dout_d = eper_q[15:8];
    if (ADDR == A_SHAPE) dout_d = 8'(shape_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tper_q  <= '{default: '0};
      vol_q   <= '{default: '0};
      tcnt_q  <= '{default: '0};
      nper_q  <= '0;  tdis_q <= '0;  ndis_q <= '0;
      eper_q  <= '0;  shape_q <= '0; pre_q  <= '0;
      ntog_q  <= 1'b0; tone_q <= '0; ncnt_q <= '0;
      lfsr_q  <= 17'h00001;
      ecnt_q  <= '0;  step_q <= '0;  inv_q  <= 1'b0;
      hold_q  <= 1'b0; dout_q <= '0; level_q <= '0;
    end else begin
      tper_q  <= tper_d;  vol_q  <= vol_d;   tcnt_q <= tcnt_d;
      nper_q  <= nper_d;  tdis_q <= tdis_d;  ndis_q <= ndis_d;
      eper_q  <= eper_d;  shape_q <= shape_d; pre_q <= pre_d;
      ntog_q  <= ntog_d;  tone_q <= tone_d;  ncnt_q <= ncnt_d;
      lfsr_q  <= lfsr_d;  ecnt_q <= ecnt_d;  step_q <= step_d;
      inv_q   <= inv_d;   hold_q <= hold_d;  dout_q <= dout_d;
      level_q <= level_d;
    end
  end

  assign DOUT  = dout_q;
  assign LEVEL = level_q;

`ifdef PSG_MIX_EN
  // Log level (0..31) to linear amplitude.
  localparam logic [7:0] LIN [32] = '{
    8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
    8'h06, 8'h07, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h11, 8'h13,
    8'h17, 8'h1B, 8'h20, 8'h25, 8'h2C, 8'h35, 8'h3E, 8'h47,
    8'h54, 8'h66, 8'h77, 8'h88, 8'hA1, 8'hC0, 8'hE0, 8'hFF};
  logic [10:0] mix_q, mix_d;

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < CH; i++) mix_d = mix_d + 11'(LIN[level_q[5*i +: 5]]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) mix_q <= '0;
    else       mix_q <= mix_d;
  end

  assign MIX = mix_q;
`else
  assign MIX = '0;
`endif

endmodule

// File: tb/tb_psg_multi.sv
module tb_psg_multi;
  logic        CLK = 1'b0;
  logic        RESET, CE, WR;
  logic [4:0]  ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic [14:0] LEVEL;
  logic [10:0] MIX;

  int checks   = 0;
  int failures = 0;

`ifdef PSG_MIX_EN
  localparam bit MIX_EN = 1'b1;
`else
  localparam bit MIX_EN = 1'b0;
`endif

  always #5 CLK = ~CLK;

  psg_multi #(.CH(3), .TW(12), .DIV(8)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WR(WR), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .LEVEL(LEVEL), .MIX(MIX)
  );

  typedef struct {
    logic [4:0] addr;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK); WR = 1'b1; ADDR = a; DIN = d;
    @(negedge CLK); WR = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic wait_change(input int limit, output int cycles, output logic [4:0] val);
    logic [4:0] prev;
    prev = LEVEL[4:0];
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (LEVEL[4:0] == prev && cycles < limit);
    val = LEVEL[4:0];
  endtask

  task automatic wait_level(input logic [4:0] v, input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge CLK);
      n++;
      if (LEVEL[4:0] == v) ok = 1'b1;
    end
  endtask

  function automatic int tri_lvl(input int k);
    int p;
    p = (k + 1) % 64;
    return (p < 32) ? p : 63 - p;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          c;
  logic [4:0]  v0, v1, v2;
  bit          ok;
  logic [16:0] lf;

  initial begin
    vecs[0]  = '{5'd0,  8'hAB, 8'hAB};
    vecs[1]  = '{5'd1,  8'hFF, 8'h0F};
    vecs[2]  = '{5'd5,  8'hA7, 8'h07};
    vecs[3]  = '{5'd6,  8'hFF, 8'h1F};
    vecs[4]  = '{5'd7,  8'hFF, 8'h07};
    vecs[5]  = '{5'd8,  8'hFD, 8'h05};
    vecs[6]  = '{5'd9,  8'h3F, 8'h1F};
    vecs[7]  = '{5'd11, 8'hE5, 8'h05};
    vecs[8]  = '{5'd12, 8'h5A, 8'h5A};
    vecs[9]  = '{5'd13, 8'hC3, 8'hC3};
    vecs[10] = '{5'd14, 8'hFF, 8'h0F};
    vecs[11] = '{5'd15, 8'h12, 8'hFF};
    vecs[12] = '{5'd31, 8'h00, 8'hFF};

    RESET = 1'b1; CE = 1'b1; WR = 1'b0; ADDR = 5'd0; DIN = 8'd0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check("reset_dout", DOUT, 0);
    check("reset_level", LEVEL, 0);
    check("reset_mix", MIX, 0);

    // Register write / readback table
    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].addr, vecs[i].wdat);
      @(negedge CLK);
      check($sformatf("readback_addr%0d", vecs[i].addr), DOUT, vecs[i].exp);
    end

    // Tone: period 4, fixed volume 15 -> 0/31 square, 32 CLK per half
    do_reset;
    wr(5'd0, 8'd4); wr(5'd1, 8'd0); wr(5'd7, 8'd0); wr(5'd8, 8'd7); wr(5'd9, 8'h0F);
    wait_change(100, c, v0);
    wait_change(100, c, v0);
    check("tone_level_valid", (v0 == 5'd0 || v0 == 5'd31), 1);
    wait_change(100, c, v1);
    check("tone_half1_len", c, 32);
    check("tone_half1_val", v1, (v0 == 5'd31) ? 0 : 31);
    wait_change(100, c, v2);
    check("tone_half2_len", c, 32);
    check("tone_half2_val", v2, v0);

    // Envelope shape E: triangle, one step per 8 CLK
    do_reset;
    wr(5'd12, 8'd1); wr(5'd13, 8'd0); wr(5'd7, 8'd7); wr(5'd8, 8'd7);
    wr(5'd9, 8'h10); wr(5'd14, 8'h0E);
    wait_level(5'd1, 40, ok);
    check("envE_start", ok, 1);
    repeat (4) @(negedge CLK);
    for (int k = 0; k < 70; k++) begin
      check($sformatf("envE_step%0d", k), LEVEL[4:0], tri_lvl(k));
      repeat (8) @(negedge CLK);
    end

    // Reset mid-ramp; hold CE low so the LFSR start state can be observed
    @(negedge CLK); RESET = 1'b1; CE = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    check("midreset_level", LEVEL, 0);
    check("midreset_dout", DOUT, 0);
    check("midreset_mix", MIX, 0);

    // Noise only on ch0, noise period 0: LFSR advances every 16 CLK
    wr(5'd9, 8'h0F); wr(5'd7, 8'd1); wr(5'd8, 8'd0); wr(5'd6, 8'd0);
    @(negedge CLK);
    check("noise_frozen_start", LEVEL[4:0], 31);
    CE = 1'b1;
    lf = 17'h00001;
    for (int m = 0; m < 40; m++) begin
      repeat ((m == 0) ? 8 : 16) @(negedge CLK);
      check($sformatf("noise_step%0d", m), LEVEL[4:0], lf[0] ? 31 : 0);
      lf = {lf[0] ^ lf[3], lf[16:1]};
    end

    // Envelope shape B: ramp 31 down to 0, then hold 31; rewrite restarts
    do_reset;
    wr(5'd12, 8'd1); wr(5'd13, 8'd0); wr(5'd7, 8'd7); wr(5'd8, 8'd7);
    wr(5'd9, 8'h10); wr(5'd14, 8'h0B);
    wait_level(5'd30, 40, ok);
    check("envB_start", ok, 1);
    repeat (4) @(negedge CLK);
    for (int k = 0; k < 45; k++) begin
      check($sformatf("envB_step%0d", k), LEVEL[4:0], (k <= 30) ? 30 - k : 31);
      repeat (8) @(negedge CLK);
    end
    wr(5'd14, 8'h0B);
    wait_level(5'd30, 24, ok);
    check("envB_restart_30", ok, 1);
    wait_level(5'd29, 12, ok);
    check("envB_restart_29", ok, 1);

    // Mixer latency and linear sum with all channels at full volume
    do_reset;
    wr(5'd7, 8'd7); wr(5'd8, 8'd7); wr(5'd10, 8'h0F); wr(5'd11, 8'h0F);
    wr(5'd9, 8'h0F);
    check("mix_level_w0", LEVEL, 15'h7FE0);
    @(negedge CLK);
    check("mix_level_w1", LEVEL, 15'h7FFF);
    check("mix_w1", MIX, MIX_EN ? 510 : 0);
    @(negedge CLK);
    check("mix_w2", MIX, MIX_EN ? 765 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psg_multi.md
Name: psg_multi

Overview:
- Parametrised programmable sound generator: CH square-wave tone channels, one shared 17-bit noise LFSR, one shared 32-step envelope generator.
- Simple synchronous write/read register port (no BDIR/BC bus decoding).
- Sits between the sound CPU interface and the core audio mixer, in place of fixed 3-channel PSGs.
- Emits per-channel 5-bit log levels and, optionally, a summed linear mix.

Parameters:
CH, 3, number of tone channels (1..8)
TW, 12, tone period width in bits (9..16)
DIV, 8, CE pulses per generator tick (1..16)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CE  in  1  clock enable for all generators
WR  in  1  write strobe, one CLK cycle per write
ADDR  in  5  register address (write and read)
DIN  in  8  write data
DOUT  out  8  registered read data
LEVEL  out  5*CH  per-channel 5-bit log level; channel i occupies bits [5i+4:5i]
MIX  out  11  summed linear output (see Optional Feature)

Behaviour:
- Reset and clock: RESET is synchronous, active-high; clock is CLK.
- State on RESET:
  - All registers 0.
  - All counters 0.
  - Tone outputs 0; envelope step 0, inv 0, hold 0.
  - LFSR = 17'h00001.
  - DOUT, LEVEL and MIX = 0.
- Register map (N = 2*CH):
  - Addresses 2i and 2i+1: tone period of channel i, low byte then high bits. Only TW-8 high bits are stored.
  - N: noise period, 5 bits.
  - N+1: tone-disable mask, CH bits.
  - N+2: noise-disable mask, CH bits.
  - N+3+i: volume of channel i, 5 bits; bit4 selects envelope.
  - N+3+CH and N+4+CH: envelope period, low byte and high byte.
  - N+5+CH: envelope shape, 4 bits {C, At, Al, H}.
- Writes: take effect on the clock edge where WR=1. Writes to unmapped addresses are ignored.
- Read: DOUT <= register[ADDR] every cycle (1-cycle latency). Unstored bits read 0; unmapped addresses read 0xFF.
- Prescaler:
  - Counts CE pulses and emits a tick every DIV CE pulses.
  - The noise tick fires on every 2nd tick.
- Tone counter (per channel):
  - Counts ticks up.
  - When cnt >= period-1, cnt <= 0 and the tone output toggles.
  - Period 0 behaves as period 1.
  - If a new period is written below the current count, the counter wraps on the next tick.
- Noise generator:
  - Counter works like the tone counter, but on noise ticks with the 5-bit period.
  - On wrap: lfsr <= {lfsr[0]^lfsr[3], lfsr[16:1]}.
  - Noise output = lfsr[0].
- Envelope generator:
  - A 16-bit counter on ticks uses the same compare rule as the tone counter and produces env_tick.
  - Level = (At^inv) ? step : 31-step.
  - On each env_tick with hold=0:
    - If step<31: step++.
    - If step==31 and C=0: hold=1, level forced 0 while held.
    - If step==31 and H=1: hold=1, inv^=Al, and the level stays at its final value.
    - If step==31 and Al=1 (H=0): inv toggles, step=0.
    - Otherwise: step=0.
  - A shape write, on the next edge and independent of CE: step=0, inv=0, hold=0, envelope counter=0.
- Mixer (per channel):
  - gate = (tone|tdis[i]) & (noise|ndis[i]).
  - If gate=0, level = 0.
  - If gate=1 and volume bit4=1, level = envelope level.
  - If gate=1 and volume bit4=0, level = {v[3:0], v[3]}.
  - LEVEL is registered. A write appears on LEVEL 2 CLK cycles after WR.
- Simultaneous events: if RESET and WR occur together, RESET wins. If CE=0, all generators freeze except the shape restart and register writes.

Optional Feature:
- Macro: PSG_MIX_EN.
- Defined:
  - Each channel level maps through this linear table (hex, level 0..31): 00 01 01 02 02 03 03 04 06 07 09 0A 0C 0E 11 13 17 1B 20 25 2C 35 3E 47 54 66 77 88 A1 C0 E0 FF.
  - MIX = registered sum of all CH channels, one cycle after LEVEL.
- Undefined: the MIX port stays in place, tied to 0, and no table logic is built.

Test Plan:
1. Default parameters, CE=1. Write ch0 period=4, vol=0x0F, tdis=0, ndis=0x7 → LEVEL[4:0] alternates 0 and 31, each half-period 32 CLK.
2. Shape 0xE, env period=1, ch0 vol=0x10, tdis=ndis=0x7 → level steps 0..31 then 31..0 repeating, one step per 8 CLK, 512-CLK cycle.
3. Shape 0xB, same setup → level steps 31 down to 0, then holds 31 indefinitely; a further shape write restarts from 31.
4. Write 0xFF to address 1 (TW=12), then ADDR=1 → DOUT=0x0F one cycle later. ADDR=31 → DOUT=0xFF. Noise period 0 with ndis=0 → LFSR advances every 16 CLK.
5. Assert RESET for one cycle mid-ramp of test 2 → next cycle LEVEL=0, DOUT=0, and LFSR reads back as the 17'h1 sequence start.
6. With PSG_MIX_EN defined, vols 0x0F on all 3 channels, tdis=ndis=0x7 → MIX=765 (0x2FD). Without the macro → MIX=0.
